// File: rtl/axi_lite_master.sv
// AXI-Lite initiator: converts single-beat valid/ready commands into AXI-Lite
// read or write transactions, one outstanding at a time, and reports the
// response (data + RESP code) as a one-cycle pulse on the response port.
module axi_lite_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    // command port
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [3:0]        cmd_wstrb,
    // response port
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic              err_sticky,
    input  logic              err_clr,
    // AW channel
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    // W channel
    output logic [DATA_W-1:0] m_axi_wdata,
    output logic [3:0]        m_axi_wstrb,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    // B channel
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    // AR channel
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    // R channel
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state_reg;
    logic   aw_done_reg;
    logic   w_done_reg;

    logic aw_hs;
    logic w_hs;
    logic ar_hs;
    logic b_take;
    logic r_take;

    assign aw_hs = m_axi_awvalid & m_axi_awready;
    assign w_hs  = m_axi_wvalid & m_axi_wready;
    assign ar_hs = m_axi_arvalid & m_axi_arready;

    // B is only taken once both AW and W have completed (now or earlier);
    // an early bvalid from a misbehaving slave is simply not consumed.
    assign b_take = (state_reg == WRITE) & m_axi_bvalid
                  & (aw_done_reg | aw_hs) & (w_done_reg | w_hs);

    // R is taken in the AR handshake cycle or later (arvalid low means AR done).
    assign r_take = (state_reg == READ) & m_axi_rvalid & (~m_axi_arvalid | m_axi_arready);

    // Transaction FSM with all AXI and response outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            aw_done_reg   <= 1'b0;
            w_done_reg    <= 1'b0;
            cmd_ready     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= 2'b00;
            err_sticky    <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wstrb   <= 4'h0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
        end else begin
            // rsp_valid is a pulse: only the transition into DONE raises it
            rsp_valid <= 1'b0;

            // a new error response wins over a simultaneous clear
            if (state_reg == DONE && rsp_resp != 2'b00) begin
                err_sticky <= 1'b1;
            end else if (err_clr) begin
                err_sticky <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (cmd_ready && cmd_valid) begin
                        cmd_ready    <= 1'b0;
                        aw_done_reg  <= 1'b0;
                        w_done_reg   <= 1'b0;
                        m_axi_awaddr <= cmd_addr;
                        m_axi_araddr <= cmd_addr;
                        m_axi_wdata  <= cmd_wdata;
                        m_axi_wstrb  <= cmd_wstrb;
                        if (cmd_we) begin
                            state_reg     <= WRITE;
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            m_axi_bready  <= 1'b1;
                        end else begin
                            state_reg     <= READ;
                            m_axi_arvalid <= 1'b1;
                            m_axi_rready  <= 1'b1;
                        end
                    end else begin
                        // first idle cycle after reset raises cmd_ready
                        cmd_ready <= 1'b1;
                    end
                end
                WRITE: begin
                    if (aw_hs) begin
                        m_axi_awvalid <= 1'b0;
                        aw_done_reg   <= 1'b1;
                    end
                    if (w_hs) begin
                        m_axi_wvalid <= 1'b0;
                        w_done_reg   <= 1'b1;
                    end
                    if (b_take) begin
                        m_axi_awvalid <= 1'b0;
                        m_axi_wvalid  <= 1'b0;
                        m_axi_bready  <= 1'b0;
                        rsp_resp      <= m_axi_bresp;
                        rsp_rdata     <= '0;
                        rsp_valid     <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                READ: begin
                    if (ar_hs) begin
                        m_axi_arvalid <= 1'b0;
                    end
                    if (r_take) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b0;
                        rsp_resp      <= m_axi_rresp;
                        rsp_rdata     <= m_axi_rdata;
                        rsp_valid     <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    cmd_ready <= 1'b1;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_master.sv
// Testbench for axi_lite_master: directed timing cases plus a randomized
// command mix against a delay-configurable AXI-Lite slave with its own memory,
// checked against a transaction-level reference memory.
module tb_axi_lite_master;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        err_sticky;
    logic        err_clr;
    logic [31:0] m_axi_awaddr;
    logic        m_axi_awvalid;
    logic        m_axi_awready = 1'b0;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wvalid;
    logic        m_axi_wready = 1'b0;
    logic [1:0]  m_axi_bresp = 2'b00;
    logic        m_axi_bvalid = 1'b0;
    logic        m_axi_bready;
    logic [31:0] m_axi_araddr;
    logic        m_axi_arvalid;
    logic        m_axi_arready = 1'b0;
    logic [31:0] m_axi_rdata = 32'h0;
    logic [1:0]  m_axi_rresp = 2'b00;
    logic        m_axi_rvalid = 1'b0;
    logic        m_axi_rready;

    axi_lite_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .err_sticky(err_sticky), .err_clr(err_clr),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cmd_cnt = 0;
    int rsp_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    // slave configuration
    int         aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0] cfg_bresp = 2'b00;
    logic [1:0] cfg_rresp = 2'b00;

    // slave memory (the bus target) and reference memory (expected contents)
    logic [31:0] slv_mem [16];
    logic [31:0] ref_mem [16];

    // slave state
    logic        aw_got = 1'b0, w_got = 1'b0, ar_got = 1'b0;
    logic [31:0] aw_addr_s = 32'h0, w_data_s = 32'h0, ar_addr_s = 32'h0;
    logic [3:0]  w_strb_s = 4'h0;
    int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
    logic        b_avail = 1'b0, r_avail = 1'b0;
    logic [31:0] eff_waddr = 32'h0, eff_wdata = 32'h0, eff_raddr = 32'h0;
    logic [3:0]  eff_wstrb = 4'h0;

    // Slave: consume handshakes at the edge, then drive this cycle's ready/valid
    always @(posedge clk) begin
        if (rst) begin
            aw_got = 1'b0; w_got = 1'b0; ar_got = 1'b0;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        end else begin
            if (m_axi_awvalid && m_axi_awready) begin
                aw_got = 1'b1; aw_addr_s = m_axi_awaddr; aw_cnt = 0;
            end else if (m_axi_awvalid) aw_cnt++;
            if (m_axi_wvalid && m_axi_wready) begin
                w_got = 1'b1; w_data_s = m_axi_wdata; w_strb_s = m_axi_wstrb; w_cnt = 0;
            end else if (m_axi_wvalid) w_cnt++;
            if (m_axi_bvalid && m_axi_bready) begin
                for (int b = 0; b < 4; b++)
                    if (eff_wstrb[b]) slv_mem[eff_waddr[5:2]][8*b +: 8] = eff_wdata[8*b +: 8];
                aw_got = 1'b0; w_got = 1'b0; b_cnt = 0;
            end else if (b_avail) b_cnt++;
            if (m_axi_arvalid && m_axi_arready) begin
                ar_got = 1'b1; ar_addr_s = m_axi_araddr; ar_cnt = 0;
            end else if (m_axi_arvalid) ar_cnt++;
            if (m_axi_rvalid && m_axi_rready) begin
                ar_got = 1'b0; r_cnt = 0;
            end else if (r_avail) r_cnt++;
        end
        #2;
        m_axi_awready = m_axi_awvalid && (aw_cnt >= aw_dly);
        m_axi_wready  = m_axi_wvalid && (w_cnt >= w_dly);
        eff_waddr = aw_got ? aw_addr_s : m_axi_awaddr;
        eff_wdata = w_got ? w_data_s : m_axi_wdata;
        eff_wstrb = w_got ? w_strb_s : m_axi_wstrb;
        b_avail = (aw_got || (m_axi_awvalid && m_axi_awready)) &&
                  (w_got || (m_axi_wvalid && m_axi_wready));
        m_axi_bvalid = b_avail && (b_cnt >= b_dly);
        m_axi_bresp  = m_axi_bvalid ? cfg_bresp : 2'b00;
        m_axi_arready = m_axi_arvalid && (ar_cnt >= ar_dly);
        eff_raddr = ar_got ? ar_addr_s : m_axi_araddr;
        r_avail = ar_got || (m_axi_arvalid && m_axi_arready);
        m_axi_rvalid = r_avail && (r_cnt >= r_dly);
        m_axi_rdata  = m_axi_rvalid ? slv_mem[eff_raddr[5:2]] : 32'h0;
        m_axi_rresp  = m_axi_rvalid ? cfg_rresp : 2'b00;
    end

    // Protocol monitor: valids hold with stable payload until handshake; rsp pulses count
    logic        aw_pend = 1'b0, w_pend = 1'b0, ar_pend = 1'b0, prev_rsp = 1'b0;
    logic [31:0] aw_pend_addr = 32'h0, w_pend_data = 32'h0, ar_pend_addr = 32'h0;
    logic [3:0]  w_pend_strb = 4'h0;
    always @(posedge clk) begin
        if (aw_pend) chk("aw_hold", 64'({m_axi_awvalid, m_axi_awaddr}), 64'({1'b1, aw_pend_addr}));
        if (w_pend)  chk("w_hold", 64'({m_axi_wvalid, m_axi_wstrb, m_axi_wdata}),
                         64'({1'b1, w_pend_strb, w_pend_data}));
        if (ar_pend) chk("ar_hold", 64'({m_axi_arvalid, m_axi_araddr}), 64'({1'b1, ar_pend_addr}));
        if (rsp_valid) begin
            rsp_cnt++;
            chk("rsp_single_cycle", 64'(prev_rsp), 64'(0));
        end
        prev_rsp = rsp_valid;
        aw_pend = !rst && m_axi_awvalid && !m_axi_awready; aw_pend_addr = m_axi_awaddr;
        w_pend  = !rst && m_axi_wvalid && !m_axi_wready;
        w_pend_data = m_axi_wdata; w_pend_strb = m_axi_wstrb;
        ar_pend = !rst && m_axi_arvalid && !m_axi_arready; ar_pend_addr = m_axi_araddr;
    end

    // per-transaction snapshots of cycles 1 and 2
    logic c1_aw, c1_w, c1_ar, c1_bhs, c2_aw, c2_w;
    logic noise_en = 1'b0;

    task automatic do_cmd(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, output logic [31:0] rdata,
                          output logic [1:0] resp, output int lat);
        int   n;
        int   cyc;
        logic ready_bad;
        n = 0;
        while (!cmd_ready && n < 20) begin tick(); n++; end
        chk("cmd_ready_wait", 64'(cmd_ready), 64'(1));
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = strb;
        tick();
        cmd_cnt++;
        cmd_valid = 1'b0;
        cyc = 1;
        ready_bad = 1'b0;
        while (1) begin
            if (cyc == 1) begin
                c1_aw = m_axi_awvalid; c1_w = m_axi_wvalid; c1_ar = m_axi_arvalid;
                c1_bhs = m_axi_bvalid & m_axi_bready;
            end
            if (cyc == 2) begin c2_aw = m_axi_awvalid; c2_w = m_axi_wvalid; end
            if (rsp_valid || cyc >= 300) break;
            if (cmd_ready) ready_bad = 1'b1;
            if (noise_en) begin
                cmd_valid = 1'($urandom_range(0, 1)); cmd_we = 1'($urandom_range(0, 1));
                cmd_addr = $urandom; cmd_wdata = $urandom;
            end
            tick();
            cyc++;
        end
        chk("rsp_timeout", 64'(rsp_valid), 64'(1));
        cmd_valid = 1'b0;
        rdata = rsp_rdata; resp = rsp_resp; lat = cyc;
        chk("ready_inflight", 64'(ready_bad | cmd_ready), 64'(0));
        tick();
        chk("rsp_pulse_end", 64'(rsp_valid), 64'(0));
        chk("ready_after_done", 64'(cmd_ready), 64'(1));
    endtask

    // One transaction checked against the reference memory and latency rule
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, output logic [31:0] rdata,
                       output logic [1:0] resp, output int lat);
        logic [3:0]  wi;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        int          exp_lat;
        wi = addr[5:2];
        if (we) begin
            exp_rdata = 32'h0;
            exp_resp  = cfg_bresp;
            exp_lat   = ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly + 2;
            for (int b = 0; b < 4; b++)
                if (strb[b]) ref_mem[wi][8*b +: 8] = wdata[8*b +: 8];
        end else begin
            exp_rdata = ref_mem[wi];
            exp_resp  = cfg_rresp;
            exp_lat   = ar_dly + r_dly + 2;
        end
        do_cmd(we, addr, wdata, strb, rdata, resp, lat);
        chk("rsp_rdata", 64'(rdata), 64'(exp_rdata));
        chk("rsp_resp", 64'(resp), 64'(exp_resp));
        chk("latency", 64'(lat), 64'(exp_lat));
        $display("txn %0d we=%0b addr=%h wdata=%h strb=%h rdata=%h resp=%0d lat=%0d",
                 cmd_cnt, we, addr, wdata, strb, rdata, resp, lat);
    endtask

    logic [31:0] rd;
    logic [1:0]  rs;
    int          lat;
    int          n;

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = 32'h0;
        cmd_wdata = 32'h0; cmd_wstrb = 4'h0; err_clr = 1'b0;
        for (int i = 0; i < 16; i++) begin
            slv_mem[i] = $urandom;
            ref_mem[i] = slv_mem[i];
        end
        repeat (3) tick();
        chk("reset_state", 64'({cmd_ready, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                                m_axi_rready, rsp_valid, err_sticky, rsp_resp, rsp_rdata}), 64'(0));
        rst = 1'b0;
        tick();
        chk("ready_after_reset", 64'(cmd_ready), 64'(1));

        // baseline write with an always-ready slave
        txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, rs, lat);
        chk("wr_c1_valids", 64'({c1_aw, c1_w}), 64'(2'b11));
        chk("wr_c1_b_accept", 64'(c1_bhs), 64'(1));
        chk("wr_latency_2", 64'(lat), 64'(2));

        // read-back of the same address
        txn(1'b0, 32'h10, 32'h0, 4'h0, rd, rs, lat);
        chk("rd_data_deadbeef", 64'(rd), 64'(32'hDEADBEEF));
        chk("rd_c1_arvalid", 64'(c1_ar), 64'(1));
        chk("rd_resp_okay", 64'(rs), 64'(0));

        // W stalled 3 cycles, AW immediate
        w_dly = 3;
        txn(1'b1, 32'h14, 32'h12345678, 4'b0101, rd, rs, lat);
        chk("wstall_c2_aw_low", 64'(c2_aw), 64'(0));
        chk("wstall_c2_w_high", 64'(c2_w), 64'(1));
        chk("wstall_latency_5", 64'(lat), 64'(5));
        w_dly = 0;
        txn(1'b0, 32'h14, 32'h0, 4'h0, rd, rs, lat);

        // error response, clear, and simultaneous set/clear
        cfg_rresp = 2'b10;
        txn(1'b0, 32'h10, 32'h0, 4'h0, rd, rs, lat);
        chk("err_rresp", 64'(rs), 64'(2'b10));
        chk("err_sticky_set", 64'(err_sticky), 64'(1));
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("err_sticky_clr", 64'(err_sticky), 64'(0));
        err_clr = 1'b1;
        txn(1'b0, 32'h18, 32'h0, 4'h0, rd, rs, lat);
        err_clr = 1'b0;
        chk("err_set_wins", 64'(err_sticky), 64'(1));
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("err_sticky_clr2", 64'(err_sticky), 64'(0));
        cfg_rresp = 2'b00;

        // reset while AW is stalled
        aw_dly = 1000;
        n = 0;
        while (!cmd_ready && n < 20) begin tick(); n++; end
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 32'h20; cmd_wdata = 32'hCAFEF00D; cmd_wstrb = 4'hF;
        tick();
        cmd_valid = 1'b0;
        chk("rst_mid_c1_aw", 64'(m_axi_awvalid), 64'(1));
        tick();
        chk("rst_mid_c2_aw", 64'(m_axi_awvalid), 64'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_clear", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                                  m_axi_rready, rsp_valid, cmd_ready}), 64'(0));
        tick();
        chk("rst_mid_ready", 64'(cmd_ready), 64'(1));
        chk("rst_mid_rsp", 64'({rsp_valid, rsp_resp, rsp_rdata}), 64'(0));
        aw_dly = 0;
        repeat (3) tick();

        // randomized back-to-back mix with random delays and responses
        noise_en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
            ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
            cfg_bresp = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            cfg_rresp = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            txn(1'($urandom_range(0, 1)), {26'h0, 4'($urandom_range(0, 15)), 2'b00},
                $urandom, 4'($urandom_range(0, 15)), rd, rs, lat);
        end
        noise_en = 1'b0;

        repeat (3) tick();
        chk("rsp_count", 64'(rsp_cnt), 64'(cmd_cnt));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
